// File: rtl/i2c_cmd_sequencer.sv
// UART-opcode driven I2C transaction sequencer: periodic or one-shot
// register writes and burst reads, with read bytes streamed out by valid/ready.
module i2c_cmd_sequencer #(
    parameter int         READ_LEN = 6,
    parameter int         PERIOD   = 100_000_000,
    parameter logic [6:0] MPU_ADDR = 7'h69,
    parameter logic [6:0] RTC_ADDR = 7'h68
) (
    input  logic       clk_sys,
    input  logic       cpu_resetn,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       i2c_ena,
    output logic [6:0] i2c_addr,
    output logic       i2c_rw,
    output logic [7:0] i2c_data_wr,
    input  logic       i2c_busy,
    input  logic [7:0] i2c_data_rd,
    input  logic       i2c_ack_error,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_last,
    input  logic       rd_ready,
    output logic       seq_busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_ABORT,
        S_STREAM
    } state_t;

    localparam int             PW      = $clog2(PERIOD);
    localparam logic [PW-1:0]  TICK_AT = PW'(PERIOD - 1);
    localparam logic [4:0]     RD_N    = 5'(READ_LEN + 1);
    localparam logic [3:0]     RD_LAST = 4'(READ_LEN - 1);

    state_t        state, state_n;
    logic [PW-1:0] trig_cnt;
    logic [2:0]    arm_op, arm_op_n;
    logic [2:0]    shot_op, shot_op_n;
    logic          shot_pend, shot_pend_n;
    logic          busy_prev;
    logic [6:0]    snap_addr, snap_addr_n;
    logic [7:0]    snap_reg, snap_reg_n;
    logic [4:0]    snap_len, snap_len_n;
    logic          snap_rd, snap_rd_n;
    // byte counters carry one extra bit so N = READ_LEN+1 = 16 still fits
    logic [4:0]    issued, issued_n;
    logic [4:0]    done, done_n;
    logic [3:0]    rd_idx, rd_idx_n;
    logic          rd_valid_q, rd_valid_n;
    logic          err_q, err_n;
    logic [7:0]    rd_buf [READ_LEN];
    logic          buf_we;
    logic [3:0]    buf_idx;
    logic [7:0]    rd_byte;
    logic          tick, rise, fall;
    logic          cmd_ok, start;
    logic [6:0]    cmd_op;
    logic [2:0]    start_op;
    logic          active;

    function automatic logic [7:0] op_reg(input logic [2:0] op);
        case (op)
            3'd1:    return 8'h6B;
            3'd2:    return 8'h3B;
            3'd3:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    assign tick   = (trig_cnt == TICK_AT);
    assign rise   = i2c_busy & ~busy_prev;
    assign fall   = ~i2c_busy & busy_prev;
    assign cmd_op = cmd_data[6:0];
    assign cmd_ok = cmd_valid && (cmd_op <= 7'd4);

    always_ff @(posedge clk_sys) begin
        if (!cpu_resetn) begin
            trig_cnt <= '0;
        end else if (tick) begin
            trig_cnt <= '0;
        end else begin
            trig_cnt <= trig_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!cpu_resetn) begin
            state      <= S_IDLE;
            arm_op     <= '0;
            shot_op    <= '0;
            shot_pend  <= 1'b0;
            busy_prev  <= 1'b0;
            snap_addr  <= '0;
            snap_reg   <= '0;
            snap_len   <= '0;
            snap_rd    <= 1'b0;
            issued     <= '0;
            done       <= '0;
            rd_idx     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            arm_op     <= arm_op_n;
            shot_op    <= shot_op_n;
            shot_pend  <= shot_pend_n;
            busy_prev  <= i2c_busy;
            snap_addr  <= snap_addr_n;
            snap_reg   <= snap_reg_n;
            snap_len   <= snap_len_n;
            snap_rd    <= snap_rd_n;
            issued     <= issued_n;
            done       <= done_n;
            rd_idx     <= rd_idx_n;
            rd_valid_q <= rd_valid_n;
            err_q      <= err_n;
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < READ_LEN; i++) begin
            if (buf_we && buf_idx == 4'(i)) begin
                rd_buf[i] <= i2c_data_rd;
            end
        end
    end

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < READ_LEN; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_byte = rd_buf[i];
            end
        end
    end

    always_comb begin
        state_n     = state;
        arm_op_n    = arm_op;
        shot_op_n   = shot_op;
        shot_pend_n = shot_pend;
        snap_addr_n = snap_addr;
        snap_reg_n  = snap_reg;
        snap_len_n  = snap_len;
        snap_rd_n   = snap_rd;
        issued_n    = issued;
        done_n      = done;
        rd_idx_n    = rd_idx;
        rd_valid_n  = rd_valid_q;
        err_n       = err_q;
        buf_we      = 1'b0;
        buf_idx     = '0;
        start       = 1'b0;
        start_op    = arm_op;

        if (state == S_IDLE) begin
            if (shot_pend) begin
                start       = 1'b1;
                start_op    = shot_op;
                shot_pend_n = 1'b0;
            end else if (tick && arm_op != 3'd0) begin
                start = 1'b1;
            end
        end

        // a new request lands after the start logic, so a same-cycle start
        // still runs the old command
        if (cmd_ok) begin
            err_n = 1'b0;
            if (cmd_op == 7'd0) begin
                arm_op_n = 3'd0;
            end else if (cmd_data[7]) begin
                shot_pend_n = 1'b1;
                shot_op_n   = cmd_op[2:0];
            end else begin
                arm_op_n = cmd_op[2:0];
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_REQ;
                    snap_addr_n = (start_op == 3'd4) ? RTC_ADDR : MPU_ADDR;
                    snap_reg_n  = op_reg(start_op);
                    snap_rd_n   = (start_op != 3'd1);
                    snap_len_n  = (start_op == 3'd1) ? 5'd2 : RD_N;
                    issued_n    = '0;
                    done_n      = '0;
                end
            end
            S_REQ: begin
                if (rise) begin
                    issued_n = issued + 5'd1;
                    if (issued + 5'd1 == snap_len) begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (done == snap_len && !i2c_busy) begin
                    state_n    = snap_rd ? S_STREAM : S_IDLE;
                    rd_idx_n   = '0;
                    rd_valid_n = 1'b0;
                end
            end
            S_ABORT: begin
                if (!i2c_busy) begin
                    state_n = S_IDLE;
                end
            end
            S_STREAM: begin
                if (!rd_valid_q) begin
                    rd_valid_n = 1'b1;
                end else if (rd_ready) begin
                    if (rd_idx == RD_LAST) begin
                        rd_valid_n = 1'b0;
                        state_n    = S_IDLE;
                    end else begin
                        rd_idx_n = rd_idx + 4'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (fall && (state == S_REQ || state == S_DRAIN)) begin
            done_n = done + 5'd1;
            if (snap_rd && done != 5'd0) begin
                buf_we  = 1'b1;
                buf_idx = 4'(done - 5'd1);
            end
            if (i2c_ack_error) begin
                err_n   = 1'b1;
                state_n = S_ABORT;
            end
        end
    end

    assign active = (state == S_REQ) || (state == S_DRAIN) ||
                    (state == S_ABORT);

    // only byte 0 carries a value; the setup write's data byte is 0x00
    assign i2c_ena     = (state == S_REQ);
    assign i2c_addr    = snap_addr;
    assign i2c_rw      = active && snap_rd && (issued != 5'd0);
    assign i2c_data_wr = (active && issued == 5'd0) ? snap_reg : 8'h00;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_valid_q ? rd_byte : 8'h00;
    assign rd_last     = rd_valid_q && (rd_idx == RD_LAST);
    assign seq_busy    = (state != S_IDLE);
    assign err         = err_q;

endmodule
